// File: rtl/seq_detect_prog_if.sv
// Bundle of stream, config and result signals for the programmable detector.
// master drives the stream/config side, slave is the detector.
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 4
);
    logic               seq_valid;
    logic               seq_in;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic               cnt_clr;
    logic               detect;
    logic [CNT_W-1:0]   match_cnt;
    logic               armed;

    modport master (
        output seq_valid, seq_in, cfg_we, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
        input  detect, match_cnt, armed
    );

    modport slave (
        input  seq_valid, seq_in, cfg_we, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
        output detect, match_cnt, armed
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector: runtime pattern of 1..MAX_LEN bits,
// overlapping or non-overlapping matching, registered pulse and match counter.
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_detect_prog_if.slave    bus
);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] hist_q, hist_nx;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_q, len_cfg;
    logic [LEN_W-1:0]   fill_q, fill_inc, fill_nx;
    logic               ovl_q;
    logic               sample;
    logic               hit;
    logic               armed_nx;
    logic               detect_q;
    logic               armed_q;
    logic [CNT_W-1:0]   cnt_q;

    assign sample  = bus.seq_valid && !bus.cfg_we;
    assign hist_nx = {hist_q[MAX_LEN-2:0], bus.seq_in};
    assign len_cfg = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    always_comb begin
        fill_inc = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_ONE;
        hit = sample && (len_q != '0) && (fill_inc >= len_q)
              && (((hist_nx ^ pat_q) & mask) == '0);
        // Non-overlap: the matched bits are disqualified from the next match.
        fill_nx = (hit && !ovl_q) ? '0 : fill_inc;
    end

    always_comb begin
        armed_nx = 1'b0;
        if (bus.cfg_we) begin
            armed_nx = 1'b0;
        end else if (sample) begin
            armed_nx = (len_q != '0) && (fill_nx >= len_q);
        end else begin
            armed_nx = (len_q != '0) && (fill_q >= len_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b1;
        end else if (bus.cfg_we) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= bus.cfg_pat;
            len_q  <= len_cfg;
            ovl_q  <= bus.cfg_ovl;
        end else if (sample) begin
            hist_q <= hist_nx;
            fill_q <= fill_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            detect_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            detect_q <= hit;
            armed_q  <= armed_nx;
        end
    end

    // Clear beats a simultaneous match; detect still pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (hit && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.detect    = detect_q;
    assign bus.armed     = armed_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog (MAX_LEN=8, CNT_W=2).
module tb_seq_detect_prog;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_tot  = 0;

    seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        bus.cfg_we = 1'b1; bus.cfg_pat = p; bus.cfg_len = l; bus.cfg_ovl = o;
        bus.cnt_clr = 1'b1;
        step();
        bus.cfg_we = 1'b0; bus.cnt_clr = 1'b0;
    endtask

    task automatic send(input logic b);
        bus.seq_valid = 1'b1; bus.seq_in = b;
        step();
        bus.seq_valid = 1'b0;
    endtask

    // Sends n bits MSB first; records detect/armed after each bit.
    task automatic run_bits(input logic [31:0] bits, input int n,
                            output logic [31:0] dm, output logic [31:0] am);
        dm = '0; am = '0;
        for (int k = 0; k < n; k++) begin
            send(bits[n-1-k]);
            dm[k] = bus.detect;
            am[k] = bus.armed;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tot++;
        if (bus.detect !== 1'b0 || bus.armed !== 1'b0 || bus.match_cnt !== 2'd0)
            $display("FAIL reset: det=%b arm=%b cnt=%0d want 0/0/0",
                     bus.detect, bus.armed, bus.match_cnt);
        else n_pass++;
        rst_n = 1'b1;
        step();
        send(1'b1);
        n_tot++;
        if (bus.detect !== 1'b0 || bus.armed !== 1'b0)
            $display("FAIL len0_disabled: det=%b arm=%b want 0/0", bus.detect, bus.armed);
        else n_pass++;
    endtask

    task automatic test_overlap();
        logic [31:0] dm, am;
        load(8'b0000_1001, 4'd4, 1'b1);
        run_bits(32'b1001001, 7, dm, am);
        n_tot++;
        if (dm !== 32'h48) $display("FAIL ovl_detect: got %h want 48", dm);
        else n_pass++;
        n_tot++;
        if (am !== 32'h78) $display("FAIL ovl_armed: got %h want 78", am);
        else n_pass++;
        n_tot++;
        if (bus.match_cnt !== 2'd2) $display("FAIL ovl_cnt: got %0d want 2", bus.match_cnt);
        else n_pass++;
        step();
        n_tot++;
        if (bus.detect !== 1'b0) $display("FAIL ovl_idle: det=%b want 0", bus.detect);
        else n_pass++;
    endtask

    task automatic test_nonoverlap();
        logic [31:0] dm, am;
        load(8'b0000_1001, 4'd4, 1'b0);
        run_bits(32'b1001001, 7, dm, am);
        n_tot++;
        if (dm !== 32'h08) $display("FAIL novl_detect: got %h want 08", dm);
        else n_pass++;
        n_tot++;
        if (am !== 32'h00) $display("FAIL novl_armed: got %h want 00", am);
        else n_pass++;
        n_tot++;
        if (bus.match_cnt !== 2'd1) $display("FAIL novl_cnt: got %0d want 1", bus.match_cnt);
        else n_pass++;
    endtask

    task automatic test_len2();
        logic [31:0] dm, am;
        load(8'b0000_0011, 4'd2, 1'b1);
        run_bits(32'b1111, 4, dm, am);
        n_tot++;
        if (dm !== 32'h0E) $display("FAIL len2_ovl: got %h want 0e", dm);
        else n_pass++;
        n_tot++;
        if (bus.match_cnt !== 2'd3) $display("FAIL len2_ovl_cnt: got %0d want 3", bus.match_cnt);
        else n_pass++;
        load(8'b0000_0011, 4'd2, 1'b0);
        run_bits(32'b1111, 4, dm, am);
        n_tot++;
        if (dm !== 32'h0A) $display("FAIL len2_novl: got %h want 0a", dm);
        else n_pass++;
        n_tot++;
        if (bus.match_cnt !== 2'd2) $display("FAIL len2_novl_cnt: got %0d want 2", bus.match_cnt);
        else n_pass++;
    endtask

    task automatic test_gap();
        int dcount;
        load(8'b0000_1001, 4'd4, 1'b1);
        send(1'b1);
        send(1'b0);
        dcount = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            dcount += int'(bus.detect);
        end
        send(1'b0);
        dcount += int'(bus.detect);
        n_tot++;
        if (dcount !== 0) $display("FAIL gap_early: got %0d detects want 0", dcount);
        else n_pass++;
        send(1'b1);
        n_tot++;
        if (bus.detect !== 1'b1) $display("FAIL gap_match: det=%b want 1", bus.detect);
        else n_pass++;
        step();
        n_tot++;
        if (bus.detect !== 1'b0 || bus.match_cnt !== 2'd1)
            $display("FAIL gap_after: det=%b cnt=%0d want 0/1", bus.detect, bus.match_cnt);
        else n_pass++;
    endtask

    task automatic test_cfg_collision();
        load(8'b0000_1001, 4'd4, 1'b1);
        send(1'b1); send(1'b0); send(1'b0);
        bus.seq_valid = 1'b1; bus.seq_in = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_pat = 8'b0000_1001; bus.cfg_len = 4'd4; bus.cfg_ovl = 1'b1;
        step();
        bus.seq_valid = 1'b0; bus.cfg_we = 1'b0;
        n_tot++;
        if (bus.detect !== 1'b0 || bus.armed !== 1'b0)
            $display("FAIL cfg_wins: det=%b arm=%b want 0/0", bus.detect, bus.armed);
        else n_pass++;
        send(1'b1);
        n_tot++;
        if (bus.detect !== 1'b0 || bus.armed !== 1'b0)
            $display("FAIL cfg_cleared: det=%b arm=%b want 0/0", bus.detect, bus.armed);
        else n_pass++;
    endtask

    task automatic test_saturate();
        logic [31:0] dm, am;
        load(8'b0000_0001, 4'd1, 1'b0);
        run_bits(32'b11011, 5, dm, am);
        n_tot++;
        if (dm !== 32'h1B) $display("FAIL len1_detect: got %h want 1b", dm);
        else n_pass++;
        send(1'b1);
        n_tot++;
        if (bus.match_cnt !== 2'd3) $display("FAIL cnt_sat: got %0d want 3", bus.match_cnt);
        else n_pass++;
        bus.cnt_clr = 1'b1;
        send(1'b1);
        bus.cnt_clr = 1'b0;
        n_tot++;
        if (bus.detect !== 1'b1 || bus.match_cnt !== 2'd0)
            $display("FAIL clr_prio: det=%b cnt=%0d want 1/0", bus.detect, bus.match_cnt);
        else n_pass++;
    endtask

    task automatic test_clamp();
        logic [31:0] dm, am;
        load(8'hA5, 4'd15, 1'b1);
        run_bits(32'hA5, 8, dm, am);
        n_tot++;
        if (dm !== 32'h80 || am !== 32'h80)
            $display("FAIL len_clamp: det %h arm %h want 80/80", dm, am);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] dm, am;
        load(8'b0000_1001, 4'd4, 1'b1);
        run_bits(32'b1001, 4, dm, am);
        send(1'b1); send(1'b0); send(1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_tot++;
        if (bus.match_cnt !== 2'd0 || bus.armed !== 1'b0 || bus.detect !== 1'b0)
            $display("FAIL rst_mid: cnt=%0d arm=%b det=%b want 0/0/0",
                     bus.match_cnt, bus.armed, bus.detect);
        else n_pass++;
        #3 rst_n = 1'b1;
        step();
        send(1'b1);
        n_tot++;
        if (bus.detect !== 1'b0 || bus.armed !== 1'b0)
            $display("FAIL rst_len0: det=%b arm=%b want 0/0", bus.detect, bus.armed);
        else n_pass++;
        bus.cfg_we = 1'b1; bus.cfg_pat = 8'b0000_1001; bus.cfg_len = 4'd4; bus.cfg_ovl = 1'b1;
        step();
        bus.cfg_we = 1'b0;
        run_bits(32'b1001, 4, dm, am);
        n_tot++;
        if (dm !== 32'h08 || bus.match_cnt !== 2'd1)
            $display("FAIL rst_reload: det %h cnt %0d want 08/1", dm, bus.match_cnt);
        else n_pass++;
    endtask

    initial begin
        bus.seq_valid = 1'b0; bus.seq_in = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_pat = '0; bus.cfg_len = '0; bus.cfg_ovl = 1'b0; bus.cnt_clr = 1'b0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_len2();
        test_gap();
        test_cfg_collision();
        test_saturate();
        test_clamp();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
